// File: rtl/rv32imc_3p_rf_wb_ctrl.sv
// Register-file write-back controller: arbitrates EX / mul-div / load results onto the single
// write port and tracks registers owed by long-latency ops. Macro RV32IMC_3P_RF_WB_FWD_EN adds write-port forwarding.
module rv32imc_3p_rf_wb_ctrl #(
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_wr_vld,
    input  logic [4:0]  ex_wr_addr,
    input  logic [31:0] ex_wr_dat,
    output logic        ex_wr_rdy,
    input  logic        md_wr_vld,
    input  logic [4:0]  md_wr_addr,
    input  logic [31:0] md_wr_dat,
    output logic        md_wr_rdy,
    input  logic        ld_wr_vld,
    input  logic [4:0]  ld_wr_addr,
    input  logic [31:0] ld_wr_dat,
    output logic        ld_wr_rdy,
    input  logic        iss_vld,
    input  logic        iss_long,
    input  logic [4:0]  iss_rd_addr,
    input  logic [4:0]  iss_rs1_addr,
    input  logic [4:0]  iss_rs2_addr,
    output logic        iss_stall,
    output logic        c_rf_write,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_dati,
    output logic        fwd_rs1_vld,
    output logic        fwd_rs2_vld
);

    localparam int NREQ_W = 2;
    localparam logic [NREQ_W-1:0] GNT_NONE = 2'd0;
    localparam logic [NREQ_W-1:0] GNT_EX   = 2'd1;
    localparam logic [NREQ_W-1:0] GNT_MD   = 2'd2;
    localparam logic [NREQ_W-1:0] GNT_LD   = 2'd3;
    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIM);
    localparam logic [3:0] STARVE_MAX = 4'hF;

    logic [3:0]  r_md_starve;
    logic [3:0]  r_ld_starve;
    logic        r_rr_ld;
    logic [31:0] r_pending;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_dat;

    logic              w_md_starved;
    logic              w_ld_starved;
    logic [NREQ_W-1:0] w_gnt;
    logic [4:0]        w_sel_addr;
    logic [31:0]       w_sel_dat;
    logic [3:0]        w_md_starve_next;
    logic [3:0]        w_ld_starve_next;
    logic              w_rr_ld_next;
    logic              w_set_en;
    logic              w_clr_en;
    logic [31:0]       w_pending_next;
    logic [31:0]       w_pend_eff;

    assign w_md_starved = md_wr_vld & (r_md_starve >= STARVE_THR);
    assign w_ld_starved = ld_wr_vld & (r_ld_starve >= STARVE_THR);

    // A starved MD/LD request overrides EX; otherwise EX first, then round-robin MD/LD.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_md_starved && w_ld_starved) begin
            w_gnt = r_rr_ld ? GNT_LD : GNT_MD;
        end else if (w_md_starved) begin
            w_gnt = GNT_MD;
        end else if (w_ld_starved) begin
            w_gnt = GNT_LD;
        end else if (ex_wr_vld) begin
            w_gnt = GNT_EX;
        end else if (md_wr_vld && ld_wr_vld) begin
            w_gnt = r_rr_ld ? GNT_LD : GNT_MD;
        end else if (md_wr_vld) begin
            w_gnt = GNT_MD;
        end else if (ld_wr_vld) begin
            w_gnt = GNT_LD;
        end
    end

    always_comb begin
        w_sel_addr = 5'd0;
        w_sel_dat  = 32'd0;
        case (w_gnt)
            GNT_EX: begin
                w_sel_addr = ex_wr_addr;
                w_sel_dat  = ex_wr_dat;
            end
            GNT_MD: begin
                w_sel_addr = md_wr_addr;
                w_sel_dat  = md_wr_dat;
            end
            GNT_LD: begin
                w_sel_addr = ld_wr_addr;
                w_sel_dat  = ld_wr_dat;
            end
            default: begin
                w_sel_addr = 5'd0;
                w_sel_dat  = 32'd0;
            end
        endcase
    end

    assign ex_wr_rdy = (w_gnt == GNT_EX);
    assign md_wr_rdy = (w_gnt == GNT_MD);
    assign ld_wr_rdy = (w_gnt == GNT_LD);

    always_comb begin
        w_md_starve_next = r_md_starve;
        w_ld_starve_next = r_ld_starve;
        w_rr_ld_next     = r_rr_ld;
        if (!md_wr_vld || (w_gnt == GNT_MD)) begin
            w_md_starve_next = 4'd0;
        end else if (r_md_starve != STARVE_MAX) begin
            w_md_starve_next = r_md_starve + 4'd1;
        end
        if (!ld_wr_vld || (w_gnt == GNT_LD)) begin
            w_ld_starve_next = 4'd0;
        end else if (r_ld_starve != STARVE_MAX) begin
            w_ld_starve_next = r_ld_starve + 4'd1;
        end
        if (w_gnt == GNT_MD) begin
            w_rr_ld_next = 1'b1;
        end else if (w_gnt == GNT_LD) begin
            w_rr_ld_next = 1'b0;
        end
    end

    assign w_set_en = iss_vld & iss_long & ~iss_stall & (iss_rd_addr != 5'd0);
    assign w_clr_en = (w_gnt == GNT_MD) | (w_gnt == GNT_LD);

    // Per-register scoreboard bit; a new long issue wins over a same-cycle retirement.
    assign w_pending_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_sb
            always_comb begin
                w_pending_next[gi] = r_pending[gi];
                if (w_set_en && (iss_rd_addr == 5'(gi))) begin
                    w_pending_next[gi] = 1'b1;
                end else if (w_clr_en && (w_sel_addr == 5'(gi))) begin
                    w_pending_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

`ifdef RV32IMC_3P_RF_WB_FWD_EN
    logic [31:0] w_commit_mask;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_commit
            assign w_commit_mask[gi] = r_wr_en & (r_wr_addr == 5'(gi));
        end
    endgenerate

    // The value being written this cycle is forwarded, so its owed bit no longer blocks issue.
    assign w_pend_eff  = r_pending & ~w_commit_mask;
    assign fwd_rs1_vld = r_wr_en & (r_wr_addr == iss_rs1_addr) & (r_wr_addr != 5'd0);
    assign fwd_rs2_vld = r_wr_en & (r_wr_addr == iss_rs2_addr) & (r_wr_addr != 5'd0);
`else
    assign w_pend_eff  = r_pending;
    assign fwd_rs1_vld = 1'b0;
    assign fwd_rs2_vld = 1'b0;
`endif

    assign iss_stall = iss_vld & (w_pend_eff[iss_rs1_addr] | w_pend_eff[iss_rs2_addr] |
                                  w_pend_eff[iss_rd_addr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_starve <= 4'd0;
            r_ld_starve <= 4'd0;
            r_rr_ld     <= 1'b0;
            r_pending   <= 32'd0;
        end else begin
            r_md_starve <= w_md_starve_next;
            r_ld_starve <= w_ld_starve_next;
            r_rr_ld     <= w_rr_ld_next;
            r_pending   <= w_pending_next;
        end
    end

    // Writes to x0 are accepted but never raise the RF write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_dat  <= 32'd0;
        end else if (w_gnt != GNT_NONE) begin
            r_wr_en   <= (w_sel_addr != 5'd0);
            r_wr_addr <= w_sel_addr;
            r_wr_dat  <= w_sel_dat;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign c_rf_write = r_wr_en;
    assign rd_addr    = r_wr_addr;
    assign rd_dati    = r_wr_dat;

endmodule

// File: tb/tb_rv32imc_3p_rf_wb_ctrl.sv
// Self-checking bench for rv32imc_3p_rf_wb_ctrl: directed scenarios plus a randomized run
// against a behavioural model of arbitration, write stage and scoreboard.
module tb_rv32imc_3p_rf_wb_ctrl;

    localparam int LIM = 4;
`ifdef RV32IMC_3P_RF_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int G_NONE = 0;
    localparam int G_EX   = 1;
    localparam int G_MD   = 2;
    localparam int G_LD   = 3;

    logic        clk;
    logic        rst_n;
    logic        ex_wr_vld;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_dat;
    logic        ex_wr_rdy;
    logic        md_wr_vld;
    logic [4:0]  md_wr_addr;
    logic [31:0] md_wr_dat;
    logic        md_wr_rdy;
    logic        ld_wr_vld;
    logic [4:0]  ld_wr_addr;
    logic [31:0] ld_wr_dat;
    logic        ld_wr_rdy;
    logic        iss_vld;
    logic        iss_long;
    logic [4:0]  iss_rd_addr;
    logic [4:0]  iss_rs1_addr;
    logic [4:0]  iss_rs2_addr;
    logic        iss_stall;
    logic        c_rf_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_dati;
    logic        fwd_rs1_vld;
    logic        fwd_rs2_vld;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [31:0] m_pend;
    int        m_md_wait;
    int        m_ld_wait;
    bit        m_ld_turn;
    bit        m_we;
    bit [4:0]  m_wa;
    bit [31:0] m_wd;

    rv32imc_3p_rf_wb_ctrl #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wr_vld(ex_wr_vld), .ex_wr_addr(ex_wr_addr), .ex_wr_dat(ex_wr_dat), .ex_wr_rdy(ex_wr_rdy),
        .md_wr_vld(md_wr_vld), .md_wr_addr(md_wr_addr), .md_wr_dat(md_wr_dat), .md_wr_rdy(md_wr_rdy),
        .ld_wr_vld(ld_wr_vld), .ld_wr_addr(ld_wr_addr), .ld_wr_dat(ld_wr_dat), .ld_wr_rdy(ld_wr_rdy),
        .iss_vld(iss_vld), .iss_long(iss_long), .iss_rd_addr(iss_rd_addr),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr), .iss_stall(iss_stall),
        .c_rf_write(c_rf_write), .rd_addr(rd_addr), .rd_dati(rd_dati),
        .fwd_rs1_vld(fwd_rs1_vld), .fwd_rs2_vld(fwd_rs2_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        ex_wr_vld = 0; ex_wr_addr = 0; ex_wr_dat = 0;
        md_wr_vld = 0; md_wr_addr = 0; md_wr_dat = 0;
        ld_wr_vld = 0; ld_wr_addr = 0; ld_wr_dat = 0;
        iss_vld = 0; iss_long = 0; iss_rd_addr = 0; iss_rs1_addr = 0; iss_rs2_addr = 0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_md_wait = 0; m_ld_wait = 0; m_ld_turn = 0;
        m_we = 0; m_wa = 0; m_wd = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    // Arbitration rule: overdue MD/LD first (turn breaks ties), then EX, then MD/LD by turn.
    function automatic int model_grant();
        bit md_late = md_wr_vld && (m_md_wait >= LIM);
        bit ld_late = ld_wr_vld && (m_ld_wait >= LIM);
        if (md_late && ld_late) return m_ld_turn ? G_LD : G_MD;
        if (md_late) return G_MD;
        if (ld_late) return G_LD;
        if (ex_wr_vld) return G_EX;
        if (md_wr_vld && ld_wr_vld) return m_ld_turn ? G_LD : G_MD;
        if (md_wr_vld) return G_MD;
        if (ld_wr_vld) return G_LD;
        return G_NONE;
    endfunction

    function automatic bit model_stall();
        bit [31:0] p = m_pend;
        if (FWD && m_we) p[m_wa] = 1'b0;
        return iss_vld && (p[iss_rs1_addr] || p[iss_rs2_addr] || p[iss_rd_addr]);
    endfunction

    task automatic model_commit(input int g, input bit stall);
        bit [4:0]  a = 0;
        bit [31:0] d = 0;
        if (g == G_EX) begin a = ex_wr_addr; d = ex_wr_dat; end
        if (g == G_MD) begin a = md_wr_addr; d = md_wr_dat; end
        if (g == G_LD) begin a = ld_wr_addr; d = ld_wr_dat; end
        m_md_wait = (!md_wr_vld || g == G_MD) ? 0 : ((m_md_wait < 15) ? m_md_wait + 1 : 15);
        m_ld_wait = (!ld_wr_vld || g == G_LD) ? 0 : ((m_ld_wait < 15) ? m_ld_wait + 1 : 15);
        if (g == G_MD) m_ld_turn = 1;
        if (g == G_LD) m_ld_turn = 0;
        if (g != G_NONE) begin m_we = (a != 0); m_wa = a; m_wd = d; end
        else m_we = 0;
        if (g == G_MD || g == G_LD) m_pend[a] = 0;
        if (iss_vld && iss_long && !stall && iss_rd_addr != 0) m_pend[iss_rd_addr] = 1;
        m_pend[0] = 0;
    endtask

    function automatic logic [4:0] pick_free();
        logic [4:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 5'($urandom_range(0, 31));
            if (!m_pend[a]) return a;
        end
        return 5'd0;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        iss_vld = 1; iss_rs1_addr = 5; iss_rs2_addr = 6; iss_rd_addr = 7;
        @(negedge clk);
        n_checks++; if (c_rf_write !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %0b expected 0", c_rf_write); end
        n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
        n_checks++; if (rd_dati !== 32'd0) begin n_fail++; $display("FAIL reset_rd_dati: got %0h expected 0", rd_dati); end
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", iss_stall); end
        n_checks++; if ({fwd_rs1_vld, fwd_rs2_vld} !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %0b expected 0", {fwd_rs1_vld, fwd_rs2_vld}); end
        @(posedge clk); #1 rst_n = 1; idle_inputs();
        ex_wr_vld = 1; ex_wr_addr = 6; ex_wr_dat = 32'hA5A5_A5A5;
        @(posedge clk); #1 ex_wr_vld = 0;
        n_checks++; if (c_rf_write !== 1'b1) begin n_fail++; $display("FAIL pre_async_wr: got %0b expected 1", c_rf_write); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (c_rf_write !== 1'b0) begin n_fail++; $display("FAIL async_reset_wr: got %0b expected 0", c_rf_write); end
        n_checks++; if (rd_dati !== 32'd0) begin n_fail++; $display("FAIL async_reset_dati: got %0h expected 0", rd_dati); end
        @(posedge clk); #1 rst_n = 1;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_ex_write();
        apply_reset();
        ex_wr_vld = 1; ex_wr_addr = 5; ex_wr_dat = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (ex_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL ex_rdy: got %0b expected 1", ex_wr_rdy); end
        @(posedge clk); #1 ex_wr_vld = 0;
        @(negedge clk);
        n_checks++; if (c_rf_write !== 1'b1) begin n_fail++; $display("FAIL ex_wr: got %0b expected 1", c_rf_write); end
        n_checks++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL ex_addr: got %0h expected 5", rd_addr); end
        n_checks++; if (rd_dati !== 32'h1234_5678) begin n_fail++; $display("FAIL ex_dat: got %0h expected 12345678", rd_dati); end
        @(posedge clk); #1 ex_wr_vld = 1; ex_wr_addr = 0; ex_wr_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (ex_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL ex_x0_rdy: got %0b expected 1", ex_wr_rdy); end
        @(posedge clk); #1 ex_wr_vld = 0;
        @(negedge clk);
        n_checks++; if (c_rf_write !== 1'b0) begin n_fail++; $display("FAIL ex_x0_wr: got %0b expected 0", c_rf_write); end
        $display("test_ex_write done");
    endtask

    task automatic test_md_ld_rr();
        logic [31:0] prev_dat = 0;
        apply_reset();
        md_wr_vld = 1; md_wr_addr = 12; md_wr_dat = $urandom;
        ld_wr_vld = 1; ld_wr_addr = 13; ld_wr_dat = $urandom;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if (md_wr_rdy !== ((i % 2) == 0)) begin n_fail++; $display("FAIL rr_md_rdy[%0d]: got %0b expected %0b", i, md_wr_rdy, (i % 2) == 0); end
            n_checks++; if (ld_wr_rdy !== ((i % 2) == 1)) begin n_fail++; $display("FAIL rr_ld_rdy[%0d]: got %0b expected %0b", i, ld_wr_rdy, (i % 2) == 1); end
            if (i > 0) begin
                n_checks++; if (rd_dati !== prev_dat) begin n_fail++; $display("FAIL rr_dat[%0d]: got %0h expected %0h", i, rd_dati, prev_dat); end
            end
            @(posedge clk); #1;
            if ((i % 2) == 0) begin prev_dat = md_wr_dat; md_wr_dat = $urandom; end
            else begin prev_dat = ld_wr_dat; ld_wr_dat = $urandom; end
        end
        idle_inputs();
        $display("test_md_ld_rr done");
    endtask

    task automatic test_starve();
        logic [31:0] md_d = 32'hCAFE_0012;
        apply_reset();
        ex_wr_vld = 1; ex_wr_addr = 11; ex_wr_dat = $urandom;
        md_wr_vld = 1; md_wr_addr = 12; md_wr_dat = md_d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (md_wr_rdy !== (i == 4)) begin n_fail++; $display("FAIL starve_md_rdy[%0d]: got %0b expected %0b", i, md_wr_rdy, i == 4); end
            n_checks++; if (ex_wr_rdy !== (i != 4)) begin n_fail++; $display("FAIL starve_ex_rdy[%0d]: got %0b expected %0b", i, ex_wr_rdy, i != 4); end
            @(posedge clk); #1;
            if (i != 4) ex_wr_dat = $urandom;
            else begin md_wr_addr = 14; md_wr_dat = $urandom; end
        end
        @(negedge clk);
        n_checks++; if (ex_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL starve_cleared_ex: got %0b expected 1", ex_wr_rdy); end
        n_checks++; if (rd_addr !== 5'd12) begin n_fail++; $display("FAIL starve_wr_addr: got %0h expected c", rd_addr); end
        n_checks++; if (rd_dati !== md_d) begin n_fail++; $display("FAIL starve_wr_dat: got %0h expected %0h", rd_dati, md_d); end
        @(posedge clk); #1 idle_inputs();
        $display("test_starve done");
    endtask

    task automatic test_load_stall();
        apply_reset();
        iss_vld = 1; iss_long = 1; iss_rd_addr = 7; iss_rs1_addr = 1; iss_rs2_addr = 2;
        @(negedge clk);
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL ld_issue_stall: got %0b expected 0", iss_stall); end
        @(posedge clk); #1 iss_long = 0; iss_rd_addr = 8; iss_rs1_addr = 7; iss_rs2_addr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall[%0d]: got %0b expected 1", i, iss_stall); end
            @(posedge clk); #1;
        end
        ld_wr_vld = 1; ld_wr_addr = 7; ld_wr_dat = 32'h0000_0777;
        @(negedge clk);
        n_checks++; if (ld_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL ld_accept: got %0b expected 1", ld_wr_rdy); end
        n_checks++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL ld_accept_stall: got %0b expected 1", iss_stall); end
        @(posedge clk); #1 ld_wr_vld = 0;
        @(negedge clk);
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL ld_after_stall: got %0b expected 0", iss_stall); end
        n_checks++; if (rd_addr !== 5'd7) begin n_fail++; $display("FAIL ld_wr_addr: got %0h expected 7", rd_addr); end
        @(posedge clk); #1 idle_inputs();
        $display("test_load_stall done");
    endtask

    task automatic test_set_clear_same();
        apply_reset();
        ld_wr_vld = 1; ld_wr_addr = 9; ld_wr_dat = 32'h99;
        iss_vld = 1; iss_long = 1; iss_rd_addr = 9; iss_rs1_addr = 0; iss_rs2_addr = 0;
        @(negedge clk);
        n_checks++; if (ld_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL sc_ld_rdy: got %0b expected 1", ld_wr_rdy); end
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL sc_issue_stall: got %0b expected 0", iss_stall); end
        @(posedge clk); #1 ld_wr_vld = 0; iss_long = 0; iss_rd_addr = 10; iss_rs2_addr = 9;
        @(negedge clk);
        n_checks++; if (iss_stall !== !FWD) begin n_fail++; $display("FAIL sc_stall_commit: got %0b expected %0b", iss_stall, !FWD); end
        n_checks++; if (fwd_rs2_vld !== FWD) begin n_fail++; $display("FAIL sc_fwd_rs2: got %0b expected %0b", fwd_rs2_vld, FWD); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL sc_stall: got %0b expected 1", iss_stall); end
        @(posedge clk); #1 idle_inputs();
        $display("test_set_clear_same done");
    endtask

    task automatic test_fwd();
        apply_reset();
        ex_wr_vld = 1; ex_wr_addr = 3; ex_wr_dat = 32'h3333;
        @(posedge clk); #1 ex_wr_vld = 0;
        iss_vld = 1; iss_long = 0; iss_rd_addr = 4; iss_rs1_addr = 3; iss_rs2_addr = 0;
        @(negedge clk);
        n_checks++; if (fwd_rs1_vld !== FWD) begin n_fail++; $display("FAIL fwd_rs1: got %0b expected %0b", fwd_rs1_vld, FWD); end
        n_checks++; if (fwd_rs2_vld !== 1'b0) begin n_fail++; $display("FAIL fwd_rs2_idle: got %0b expected 0", fwd_rs2_vld); end
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %0b expected 0", iss_stall); end
        @(posedge clk); #1 iss_rs1_addr = 0; iss_rs2_addr = 3;
        @(negedge clk);
        n_checks++; if (fwd_rs2_vld !== 1'b0) begin n_fail++; $display("FAIL fwd_rs2_nowr: got %0b expected 0", fwd_rs2_vld); end
        @(posedge clk); #1 idle_inputs();
        $display("test_fwd done");
    endtask

    task automatic test_random();
        int g;
        bit e_stall;
        bit e_f1;
        bit e_f2;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 0;
                #1;
                n_checks++; if (c_rf_write !== 1'b0) begin n_fail++; $display("FAIL rnd_midreset_wr: got %0b expected 0", c_rf_write); end
                @(posedge clk); #1 rst_n = 1;
                model_reset();
            end
            if (!ex_wr_vld && $urandom_range(0, 1) == 1) begin
                ex_wr_vld = 1; ex_wr_addr = pick_free(); ex_wr_dat = $urandom;
            end
            if (!md_wr_vld && $urandom_range(0, 2) == 0) begin
                md_wr_vld = 1; md_wr_addr = 5'($urandom_range(0, 31)); md_wr_dat = $urandom;
            end
            if (!ld_wr_vld && $urandom_range(0, 2) == 0) begin
                ld_wr_vld = 1; ld_wr_addr = 5'($urandom_range(0, 31)); ld_wr_dat = $urandom;
            end
            iss_vld = 1'($urandom_range(0, 1));
            iss_long = ($urandom_range(0, 3) == 0);
            iss_rd_addr = 5'($urandom_range(0, 31));
            iss_rs1_addr = 5'($urandom_range(0, 31));
            iss_rs2_addr = 5'($urandom_range(0, 31));
            if (iss_long && ex_wr_vld && iss_rd_addr == ex_wr_addr) iss_long = 0;
            n_checks++; if (ex_wr_vld && m_pend[ex_wr_addr]) begin n_fail++; $display("FAIL rnd_ex_to_pending[%0d]: got addr %0d pending expected not pending", i, ex_wr_addr); end
            @(negedge clk);
            g = model_grant();
            e_stall = model_stall();
            e_f1 = FWD && m_we && (m_wa == iss_rs1_addr) && (m_wa != 0);
            e_f2 = FWD && m_we && (m_wa == iss_rs2_addr) && (m_wa != 0);
            n_checks++; if ({ex_wr_rdy, md_wr_rdy, ld_wr_rdy} !== {g == G_EX, g == G_MD, g == G_LD}) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got ex/md/ld %0b expected %0b", i, {ex_wr_rdy, md_wr_rdy, ld_wr_rdy}, {g == G_EX, g == G_MD, g == G_LD}); end
            n_checks++; if (iss_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", i, iss_stall, e_stall); end
            n_checks++; if ({fwd_rs1_vld, fwd_rs2_vld} !== {e_f1, e_f2}) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0b expected %0b", i, {fwd_rs1_vld, fwd_rs2_vld}, {e_f1, e_f2}); end
            n_checks++; if (c_rf_write !== m_we) begin n_fail++; $display("FAIL rnd_wr[%0d]: got %0b expected %0b", i, c_rf_write, m_we); end
            if (m_we) begin
                n_checks++; if ({rd_addr, rd_dati} !== {m_wa, m_wd}) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %0h:%0h expected %0h:%0h", i, rd_addr, rd_dati, m_wa, m_wd); end
            end
            @(posedge clk);
            model_commit(g, e_stall);
            #1;
            if (g == G_EX) ex_wr_vld = 0;
            if (g == G_MD) md_wr_vld = 0;
            if (g == G_LD) ld_wr_vld = 0;
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_ex_write();
        test_md_ld_rr();
        test_starve();
        test_load_stall();
        test_set_clear_same();
        test_fwd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
